pipelined_add_sub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake. It is the multi-cycle successor of the team's 4-bit ripple add/subtract block.
- Operands are split into CHUNK-bit slices; one slice is resolved per pipeline stage, and the carry is registered between stages.
- Sits in the datapath between operand registers and the result/flag writeback.

---
 rtl/add_sub_pkg.sv | 13 +
 rtl/add_sub_slice.sv | 33 +++
 rtl/pipelined_add_sub.sv | 140 ++++++++++++++
 tb/tb_pipelined_add_sub.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared opcode constants and flag bundle for the pipelined add/subtract datapath.
package add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic cout;
        logic ovfl;
        logic zero;
    } flags_t;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational CHUNK-bit ripple slice: sum = a + (b ^ sub) + cin.
module add_sub_slice
    import add_sub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] bx;

    always_comb begin
        bx   = b ^ {CHUNK{sub}};
        c    = '0;
        c[0] = cin;
        sum  = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract, one CHUNK slice per stage, global-enable valid/ready pipeline.
// Optional saturation on signed overflow: define PIPELINED_ADD_SUB_SAT_EN.
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_rslt,
    output logic             out_cout,
    output logic             out_ovfl,
    output logic             out_zero
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;
    logic             res_v_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] rslt_d;
    flags_t           flg_q;
    flags_t           flg_d;
    logic             cm_last;

    assign adv      = !res_v_q || out_ready;
    assign in_ready = adv && !rst;

    // Each stage's *_in signals are the operands still to be consumed; the
    // register bank feeding stage k lives inside stage k and only keeps
    // operand bits from slice k upward plus the result bits below it.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK - 1;

        logic             v_in;
        logic             sub_in;
        logic             c_in;
        logic [WIDTH-1:LO] a_in;
        logic [WIDTH-1:LO] b_in;
        logic [CHUNK-1:0] sum;
        logic             co;
        logic [HI:0]      acc;

        if (k == STAGES - 1) begin : g_last
            add_sub_slice #(.CHUNK(CHUNK)) u_slice (
                .a(a_in[HI:LO]), .b(b_in[HI:LO]), .sub(sub_in), .cin(c_in),
                .sum(sum), .cout(co), .c_msb(cm_last)
            );
        end else begin : g_mid
            logic cm_unused;
            add_sub_slice #(.CHUNK(CHUNK)) u_slice (
                .a(a_in[HI:LO]), .b(b_in[HI:LO]), .sub(sub_in), .cin(c_in),
                .sum(sum), .cout(co), .c_msb(cm_unused)
            );
        end

        if (k == 0) begin : g_head
            assign v_in   = in_valid;
            assign sub_in = in_sub;
            assign c_in   = (in_sub == OP_SUB);
            assign a_in   = in_a;
            assign b_in   = in_b;
            assign acc    = sum;
        end else begin : g_body
            logic              v_q;
            logic              sub_q;
            logic              c_q;
            logic [WIDTH-1:LO] a_q;
            logic [WIDTH-1:LO] b_q;
            logic [LO-1:0]     r_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    sub_q <= 1'b0;
                    c_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    r_q   <= '0;
                end else if (adv) begin
                    v_q   <= g_st[k-1].v_in;
                    sub_q <= g_st[k-1].sub_in;
                    c_q   <= g_st[k-1].co;
                    a_q   <= g_st[k-1].a_in[WIDTH-1:LO];
                    b_q   <= g_st[k-1].b_in[WIDTH-1:LO];
                    r_q   <= g_st[k-1].acc;
                end
            end

            assign v_in   = v_q;
            assign sub_in = sub_q;
            assign c_in   = c_q;
            assign a_in   = a_q;
            assign b_in   = b_q;
            assign acc    = {sum, r_q};
        end
    end

    always_comb begin
        rslt_d     = g_st[STAGES-1].acc;
        flg_d.cout = g_st[STAGES-1].co;
        flg_d.ovfl = g_st[STAGES-1].co ^ cm_last;
`ifdef PIPELINED_ADD_SUB_SAT_EN
        // Overflow direction follows A's sign (A and B' share it on overflow).
        if (flg_d.ovfl) begin
            rslt_d = g_st[STAGES-1].a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flg_d.zero = g_st[STAGES-1].v_in && (rslt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_v_q <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
        end else if (adv) begin
            res_v_q <= g_st[STAGES-1].v_in;
            res_q   <= rslt_d;
            flg_q   <= flg_d;
        end
    end

    assign out_valid = res_v_q;
    assign out_rslt  = res_q;
    assign out_cout  = flg_q.cout;
    assign out_ovfl  = flg_q.ovfl;
    assign out_zero  = flg_q.zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub at WIDTH=8, CHUNK=4 (two stages).
module tb_pipelined_add_sub;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int ST = W / C;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_rslt;
    logic         out_cout;
    logic         out_ovfl;
    logic         out_zero;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    pipelined_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rslt(out_rslt), .out_cout(out_cout),
        .out_ovfl(out_ovfl), .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t        e;
        int          sa, sb, tr;
        int unsigned ua, ub, raw;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        tr  = s ? sa - sb : sa + sb;
        ua  = a;
        ub  = b;
        raw = s ? ua + (1 << W) - ub : ua + ub;
        e.c = (raw >= (1 << W));
        e.r = raw[W-1:0];
        e.o = (tr > (1 << (W-1)) - 1) || (tr < -(1 << (W-1)));
`ifdef PIPELINED_ADD_SUB_SAT_EN
        if (e.o) e.r = (tr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic exp_t observed();
        return {out_rslt, out_cout, out_ovfl, out_zero};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during got %b want 0", in_ready); end
        n_chk++; if (observed() !== exp_t'(0)) begin n_fail++; $display("FAIL reset_outputs got %h want 0", observed()); end
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_after got %b want 0", out_valid); end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [7] = '{8'h3A, 8'h05, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h80};
        logic [W-1:0] tb [7] = '{8'h05, 8'h05, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h80};
        logic         ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t         te [7];
        int           lat;
        te[0] = {8'h3F, 3'b000};
        te[1] = {8'h00, 3'b101};
        te[2] = {8'hFF, 3'b000};
        te[3] = {8'h80, 3'b010};
        te[4] = {8'h7F, 3'b110};
        te[5] = {8'hFE, 3'b100};
        te[6] = {8'h00, 3'b111};
`ifdef PIPELINED_ADD_SUB_SAT_EN
        te[3] = {8'h7F, 3'b010};
        te[4] = {8'h80, 3'b110};
        te[6] = {8'h80, 3'b110};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_a = ta[i]; in_b = tb[i]; in_sub = ts[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_chk++; if (lat !== ST) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, ST); end
            n_chk++; if (observed() !== te[i]) begin n_fail++; $display("FAIL directed_result[%0d] got %h want %h", i, observed(), te[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [W-1:0] sa [4] = '{8'h01, 8'h02, 8'h10, 8'hFF};
        logic [W-1:0] sb [4] = '{8'h01, 8'h02, 8'h01, 8'h01};
        logic         ss [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_t         se [4];
        int           k = 0;
        se[0] = {8'h02, 3'b000};
        se[1] = {8'h04, 3'b000};
        se[2] = {8'h0F, 3'b100};
        se[3] = {8'h00, 3'b101};
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 4) begin
                in_valid = 1'b1; in_a = sa[cyc]; in_b = sb[cyc]; in_sub = ss[cyc];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                n_chk++; if (k >= 4) begin n_fail++; $display("FAIL stream_extra_beat got beat %0d want only 4", k); end
                else begin
                    n_chk++; if (cyc !== k + ST) begin n_fail++; $display("FAIL stream_cycle[%0d] got %0d want %0d", k, cyc, k + ST); end
                    n_chk++; if (observed() !== se[k]) begin n_fail++; $display("FAIL stream_result[%0d] got %h want %h", k, observed(), se[k]); end
                end
                k++;
            end
            @(negedge clk);
        end
        n_chk++; if (k !== 4) begin n_fail++; $display("FAIL stream_count got %0d want 4", k); end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t held, e;
        logic held_v = 1'b0;
        int   n_in = 0, n_out = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (cyc < 8);
            in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
            #1;
            if (held_v) begin
                n_chk++; if (observed() !== held || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold got %h want %h", observed(), held); end
            end
            if (out_valid && !out_ready) begin
                n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            end
            if (out_valid && out_ready) begin
                n_out++;
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL bp_unexpected_beat got %h want none", observed()); end
                else begin
                    e = q.pop_front();
                    if (observed() !== e) begin n_fail++; $display("FAIL bp_result got %h want %h", observed(), e); end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_sub));
                n_in++;
            end
            held_v = out_valid && !out_ready;
            held   = observed();
            @(negedge clk);
        end
        n_chk++; if (n_out !== n_in || q.size() != 0) begin n_fail++; $display("FAIL bp_count got %0d out want %0d", n_out, n_in); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t held, e;
        logic held_v = 1'b0;
        int   n_in = 0, n_out = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(9) < 7);
            in_valid  = (cyc < 360) && ($urandom_range(9) < 7);
            if (cyc >= 360) out_ready = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
            #1;
            if (held_v) begin
                n_chk++; if (observed() !== held || out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_hold got %h want %h", observed(), held); end
            end
            if (out_valid && out_ready) begin
                n_out++;
                n_chk++;
                if (q.size() == 0) begin n_fail++; $display("FAIL rnd_unexpected_beat got %h want none", observed()); end
                else begin
                    e = q.pop_front();
                    if (observed() !== e) begin n_fail++; $display("FAIL rnd_result got %h want %h", observed(), e); end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_sub));
                n_in++;
            end
            held_v = out_valid && !out_ready;
            held   = observed();
            @(negedge clk);
        end
        n_chk++; if (n_out !== n_in || q.size() != 0) begin n_fail++; $display("FAIL rnd_count got %0d out want %0d", n_out, n_in); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 8'h11 * (i + 1); in_b = 8'h22; in_sub = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_chk++; if (observed() !== exp_t'(0)) begin n_fail++; $display("FAIL midrst_outputs got %h want 0", observed()); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_beat[%0d] got %b want 0", i, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
